wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 5-stage RV32I pipeline, directly downstream of the access stage. Registers the access-stage results (MEM/WB boundary), extracts and sign/zero-extends load data from the raw data-memory word, and drives the register-file write port, which also serves as the forwarding source for earlier stages. Also maintains the 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, retired-instruction counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  access stage holds a real instruction this cycle
- stall  in  1  hold current WB contents, ignore inputs
- flush  in  1  kill current WB contents (priority over stall)
- alu_or_ia4  in  XLEN  ALU result, or PC+4 for jumps; for loads, the byte address
- data  in  XLEN  raw 32-bit aligned word read from data memory
- is_load  in  1  instruction is a load
- mem_op  in  3  memory op code, RISC-V funct3 encoding
- rd  in  5  destination register
- wb_enable  in  1  instruction writes rd
- wb_valid  out  1  WB holds a live instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- misalign  out  1  live load in WB is misaligned
- instret  out  CNT_W  retired-instruction count

## Operation
- Pipeline register fields: valid, result (alu_or_ia4), word (data), is_load, mem_op, rd, wb_enable.
- Capture at rising edge:
  - flush=1: valid←0; other fields don't-care.
  - Otherwise, stall=1: all fields hold.
  - Otherwise: all fields ← inputs, valid←in_valid.
- Load extraction, combinational on registered fields, using a = result[1:0]:
  - LB (000): sign-extend byte a.
  - LBU (100): zero-extend byte a.
  - LH (001): sign-extend halfword a[1].
  - LHU (101): zero-extend halfword a[1].
  - LW (010): full word.
  - Other codes: word passed through.
- misalign = valid & is_load & (LH/LHU with a[0]=1, or LW with a≠0).
- rf_wdata = is_load ? extracted : result.
- rf_waddr = rd.
- rf_we = valid & wb_enable & (rd≠0) & ~misalign. x0 is never written.
- wb_valid = valid.
- instret increments by 1 on every edge that sets valid←1 from in_valid (no flush, no stall). A flushed or stalled-out instruction is never counted. Wraps modulo 2^CNT_W.

## Timing
- Latency: inputs presented in cycle N appear on rf_* in cycle N+1. Register-file write commits at the edge ending cycle N+1.
- All outputs are combinational from the register only; no input-to-output combinational path.
- During a stall, rf_we stays asserted with identical address/data, so repeated writes are idempotent.
- flush and stall together: flush wins, valid←0, counter unchanged.
- Reset (asynchronous assert, any time, including mid-stall):
  - valid=0, instret=0, all fields 0.
  - Outputs: wb_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, misalign=0.
  - Release is synchronous to clk via the system reset synchronizer.

## Structure
- Package wb_pkg: mem_op constants MEM_LB=3'b000, MEM_LH=3'b001, MEM_LW=3'b010, MEM_LBU=3'b100, MEM_LHU=3'b101. The same constants are used by the data-memory and decode blocks.
- Sub-module load_ext (combinational): inputs word, mem_op, addr[1:0]; outputs extracted value and misalign. It is reused for its byte-lane logic by the store path.
- Top level holds only the pipeline register, the write mux, and the counter.

## Test plan
- LB, result=0x1003, data=0x80FF_1234 → rf_wdata=0xFFFF_FF80, rf_we=1 one cycle later; LBU at the same address → 0x0000_0080.
- LH, result=0x2002, data=0x8001_7FFF → rf_wdata=0xFFFF_8001. LH at 0x2001 → misalign=1, rf_we=0, instret still increments.
- Non-load, rd=0, wb_enable=1, result=0xDEAD_BEEF → rf_we=0, wb_valid=1. Same with rd=5 → rf_we=1, rf_waddr=5, rf_wdata=0xDEAD_BEEF.
- Three back-to-back valid instructions with stall high on the 2nd edge → 2nd instruction held for 2 cycles with constant rf_* outputs, instret ends at 3.
- flush and stall asserted together with in_valid=1 → wb_valid=0 next cycle, instret unchanged.
- reset asserted asynchronously mid-cycle with valid=1 and instret=7 → all outputs and instret read 0 immediately, before the next edge.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared memory-op encodings (RISC-V load funct3) for WB,
//               data-memory and decode blocks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef logic [2:0] mem_op_t;

    localparam mem_op_t MEM_LB  = 3'b000;
    localparam mem_op_t MEM_LH  = 3'b001;
    localparam mem_op_t MEM_LW  = 3'b010;
    localparam mem_op_t MEM_LBU = 3'b100;
    localparam mem_op_t MEM_LHU = 3'b101;

    // True for halfword ops, which only need the low address bit clear.
    function automatic logic is_half_op(input mem_op_t op);
        return (op == MEM_LH) || (op == MEM_LHU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_ext.sv
// ============================================================================
// Module      : load_ext
// Description : Byte/halfword lane selection with sign/zero extension and
//               misalignment detection for an aligned 32-bit memory word.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      mem_op,
    input  logic [1:0]      addr,
    output logic [XLEN-1:0] extracted,
    output logic            misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        extracted = word;
        case (mem_op)
            MEM_LB:  extracted = {{(XLEN-8){w_byte[7]}}, w_byte};
            MEM_LBU: extracted = {{(XLEN-8){1'b0}}, w_byte};
            MEM_LH:  extracted = {{(XLEN-16){w_half[15]}}, w_half};
            MEM_LHU: extracted = {{(XLEN-16){1'b0}}, w_half};
            default: extracted = word;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        if (is_half_op(mem_op)) begin
            misalign = addr[0];
        end else if (mem_op == MEM_LW) begin
            misalign = (addr != 2'b00);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : RV32I write-back stage: MEM/WB register, load extraction,
//               register-file write port and retired-instruction counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  alu_or_ia4,
    input  logic [XLEN-1:0]  data,
    input  logic             is_load,
    input  logic [2:0]       mem_op,
    input  logic [4:0]       rd,
    input  logic             wb_enable,
    output logic             wb_valid,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             misalign,
    output logic [CNT_W-1:0] instret
);

    logic             r_valid;
    logic [XLEN-1:0]  r_result;
    logic [XLEN-1:0]  r_word;
    logic             r_is_load;
    logic [2:0]       r_mem_op;
    logic [4:0]       r_rd;
    logic             r_wb_enable;
    logic [CNT_W-1:0] r_instret;

    logic [XLEN-1:0]  w_extracted;
    logic             w_ext_misalign;
    logic             w_misalign;
    logic             w_retire;

    // Only an instruction actually accepted into WB counts as retired.
    assign w_retire = in_valid & ~flush & ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_word      <= '0;
            r_is_load   <= 1'b0;
            r_mem_op    <= 3'b000;
            r_rd        <= 5'd0;
            r_wb_enable <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (!stall) begin
            r_valid     <= in_valid;
            r_result    <= alu_or_ia4;
            r_word      <= data;
            r_is_load   <= is_load;
            r_mem_op    <= mem_op;
            r_rd        <= rd;
            r_wb_enable <= wb_enable;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .word      (r_word),
        .mem_op    (r_mem_op),
        .addr      (r_result[1:0]),
        .extracted (w_extracted),
        .misalign  (w_ext_misalign)
    );

    assign w_misalign = r_valid & r_is_load & w_ext_misalign;

    // A misaligned load still retires but must not corrupt the register file.
    assign wb_valid = r_valid;
    assign misalign = w_misalign;
    assign rf_waddr = r_rd;
    assign rf_wdata = r_is_load ? w_extracted : r_result;
    assign rf_we    = r_valid & r_wb_enable & (r_rd != 5'd0) & ~w_misalign;
    assign instret  = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed table-driven bench for wb_stage plus stall, flush
//               and asynchronous-reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [XLEN-1:0]  alu_or_ia4;
    logic [XLEN-1:0]  data;
    logic             is_load;
    logic [2:0]       mem_op;
    logic [4:0]       rd;
    logic             wb_enable;
    logic             wb_valid;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             misalign;
    logic [CNT_W-1:0] instret;

    int n_tests;
    int n_fail;

    wb_stage #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .stall      (stall),
        .flush      (flush),
        .alu_or_ia4 (alu_or_ia4),
        .data       (data),
        .is_load    (is_load),
        .mem_op     (mem_op),
        .rd         (rd),
        .wb_enable  (wb_enable),
        .wb_valid   (wb_valid),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .misalign   (misalign),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        ld;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        we_en;
        logic [31:0] res;
        logic [31:0] word;
        logic        x_valid;
        logic        x_we;
        logic [4:0]  x_waddr;
        logic [31:0] x_wdata;
        logic        x_mis;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic [2:0] op,
                         input logic [4:0] r, input logic en,
                         input logic [31:0] res, input logic [31:0] w,
                         input logic st, input logic fl);
        @(negedge clk);
        in_valid   = v;
        is_load    = ld;
        mem_op     = op;
        rd         = r;
        wb_enable  = en;
        alu_or_ia4 = res;
        data       = w;
        stall      = st;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string nm, input logic v, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd, input logic mis);
        check({nm, ".wb_valid"}, 64'(wb_valid), 64'(v));
        check({nm, ".rf_we"},    64'(rf_we),    64'(we));
        check({nm, ".rf_waddr"}, 64'(rf_waddr), 64'(wa));
        check({nm, ".rf_wdata"}, 64'(rf_wdata), 64'(wd));
        check({nm, ".misalign"}, 64'(misalign), 64'(mis));
    endtask

    initial begin
        logic [63:0] base;
        n_tests = 0;
        n_fail  = 0;

        //            name       v  ld  op      rd  en  result        data          valid we waddr wdata         mis
        vecs[0]  = '{"lb_neg",   1, 1, 3'b000, 3,  1, 32'h0000_1003, 32'h80FF_1234, 1, 1, 3,  32'hFFFF_FF80, 0};
        vecs[1]  = '{"lbu",      1, 1, 3'b100, 3,  1, 32'h0000_1003, 32'h80FF_1234, 1, 1, 3,  32'h0000_0080, 0};
        vecs[2]  = '{"lh_hi",    1, 1, 3'b001, 4,  1, 32'h0000_2002, 32'h8001_7FFF, 1, 1, 4,  32'hFFFF_8001, 0};
        vecs[3]  = '{"lhu_hi",   1, 1, 3'b101, 4,  1, 32'h0000_2002, 32'h8001_7FFF, 1, 1, 4,  32'h0000_8001, 0};
        vecs[4]  = '{"lh_mis",   1, 1, 3'b001, 4,  1, 32'h0000_2001, 32'h8001_7FFF, 1, 0, 4,  32'h0000_7FFF, 1};
        vecs[5]  = '{"alu_x0",   1, 0, 3'b000, 0,  1, 32'hDEAD_BEEF, 32'h0,         1, 0, 0,  32'hDEAD_BEEF, 0};
        vecs[6]  = '{"alu_x5",   1, 0, 3'b000, 5,  1, 32'hDEAD_BEEF, 32'h0,         1, 1, 5,  32'hDEAD_BEEF, 0};
        vecs[7]  = '{"lw",       1, 1, 3'b010, 9,  1, 32'h0000_3000, 32'h1234_5678, 1, 1, 9,  32'h1234_5678, 0};
        vecs[8]  = '{"lw_mis",   1, 1, 3'b010, 9,  1, 32'h0000_3002, 32'h1234_5678, 1, 0, 9,  32'h1234_5678, 1};
        vecs[9]  = '{"lb_b1",    1, 1, 3'b000, 10, 1, 32'h0000_0001, 32'h0000_A500, 1, 1, 10, 32'hFFFF_FFA5, 0};
        vecs[10] = '{"bubble",   0, 1, 3'b010, 7,  1, 32'h0000_0002, 32'h1111_2222, 0, 0, 7,  32'h1111_2222, 0};
        vecs[11] = '{"alu_lhop", 1, 0, 3'b001, 11, 1, 32'h0000_1001, 32'h5555_AAAA, 1, 1, 11, 32'h0000_1001, 0};
        vecs[12] = '{"ld_op011", 1, 1, 3'b011, 12, 1, 32'h0000_0000, 32'hCAFE_F00D, 1, 1, 12, 32'hCAFE_F00D, 0};

        reset = 1'b0;
        in_valid = 0; stall = 0; flush = 0; alu_or_ia4 = '0; data = '0;
        is_load = 0; mem_op = 3'b000; rd = 5'd0; wb_enable = 0;
        #12;
        check_outs("reset", 0, 0, 0, 32'h0, 0);
        check("reset.instret", instret, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table vectors: one per cycle, checked one edge after presentation.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].we_en,
                  vecs[i].res, vecs[i].word, 1'b0, 1'b0);
            tick();
            check_outs(vecs[i].name, vecs[i].x_valid, vecs[i].x_we, vecs[i].x_waddr,
                       vecs[i].x_wdata, vecs[i].x_mis);
        end
        check("table.instret", instret, 64'd12);

        // Back-to-back A, B, C with a stall holding B for an extra cycle.
        base = instret;
        drive(1, 0, 3'b000, 1, 1, 32'h111, 32'h0, 0, 0);
        tick();
        check_outs("seqA", 1, 1, 1, 32'h111, 0);
        drive(1, 0, 3'b000, 2, 1, 32'h222, 32'h0, 0, 0);
        tick();
        check_outs("seqB", 1, 1, 2, 32'h222, 0);
        drive(1, 0, 3'b000, 3, 1, 32'h333, 32'h0, 1, 0);
        tick();
        check_outs("seqB_hold", 1, 1, 2, 32'h222, 0);
        check("seq.instret_stall", instret, base + 64'd2);
        drive(1, 0, 3'b000, 3, 1, 32'h333, 32'h0, 0, 0);
        tick();
        check_outs("seqC", 1, 1, 3, 32'h333, 0);
        check("seq.instret", instret, base + 64'd3);

        // Flush wins over stall; nothing counted.
        base = instret;
        drive(1, 0, 3'b000, 6, 1, 32'h666, 32'h0, 1, 1);
        tick();
        check("flush_stall.wb_valid", 64'(wb_valid), 64'd0);
        check("flush_stall.rf_we", 64'(rf_we), 64'd0);
        check("flush_stall.instret", instret, base);
        drive(1, 0, 3'b000, 6, 1, 32'h666, 32'h0, 0, 1);
        tick();
        check("flush.wb_valid", 64'(wb_valid), 64'd0);
        check("flush.instret", instret, base);

        // Asynchronous reset mid-cycle with a live instruction and instret=7.
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 3'b000, 8, 1, 32'h0000_0888, 32'h0, 0, 0);
            tick();
        end
        check("pre_reset.instret", instret, 64'd7);
        check("pre_reset.wb_valid", 64'(wb_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 32'h0, 0);
        check("async_reset.instret", instret, 64'd0);
        drive(0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 0);
        reset = 1'b1;
        tick();
        check_outs("post_reset", 0, 0, 0, 32'h0, 0);
        check("post_reset.instret", instret, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
